// File: rtl/da_tap_slicer_pkg.sv
// Shared definitions for the distributed-arithmetic tap slicer:
// default geometry, slice index width and the serialiser state encoding.
package da_pkg;

  localparam int TAPS_DEF  = 64;
  localparam int WIDTH_DEF = 16;
  localparam int IDX_W     = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/da_tap_slicer_if.sv
// Sample-in / slice-out handshake bundle for da_tap_slicer.
// The slave modport is the slicer itself; the master drives samples and takes slices.
interface da_tap_slicer_if #(
  parameter int TAPS  = da_pkg::TAPS_DEF,
  parameter int WIDTH = da_pkg::WIDTH_DEF
);

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_sample;
  logic                       slice_valid;
  logic                       slice_ready;
  logic [TAPS-1:0]            slice;
  logic [$clog2(WIDTH)-1:0]   slice_idx;
  logic                       slice_last;
  logic                       line_full;

  modport slave (
    input  in_valid, in_sample, slice_ready,
    output in_ready, slice_valid, slice, slice_idx, slice_last, line_full
  );

  modport master (
    output in_valid, in_sample, slice_ready,
    input  in_ready, slice_valid, slice, slice_idx, slice_last, line_full
  );

endinterface

// File: rtl/da_tap_slicer_tap_bit_serializer.sv
// Per-tap parallel-load, right-shift register; bit 0 is the current slice bit.
// Load wins over shift so a new sample can replace the last slice in one edge.
module tap_bit_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_din;
    end else if (i_shift) begin
      r_sr <= {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  assign o_bit = r_sr[0];

endmodule

// File: rtl/da_tap_slicer.sv
// TAPS-deep sample delay line whose snapshot is emitted as WIDTH bit-slices,
// LSB first, over a valid/ready handshake; feeds the DA lookup/accumulate stage.
module da_tap_slicer
  import da_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  da_tap_slicer_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(TAPS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_tap     [TAPS];
  logic [WIDTH-1:0] w_tap_nxt [TAPS];
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_inc;
  logic             r_last;
  logic [CW-1:0]    r_count;
  logic [TAPS-1:0]  w_slice;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_step;
  logic             w_wrap;

  // Handshake decode: a wrap on the sign slice may take the next sample in the same edge
  always_comb begin
    w_step     = (r_state == BUSY) & bus.slice_ready & ~clear;
    w_wrap     = w_step & r_last;
    w_in_ready = ~clear & ((r_state == IDLE) | ((r_state == BUSY) & r_last & bus.slice_ready));
    w_accept   = w_in_ready & bus.in_valid;
    w_idx_inc  = r_idx + IW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = BUSY;
      BUSY:    if (w_wrap)   w_state_nxt = w_accept ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (clear) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Post-shift history; the serialisers load this same value on accept
  always_comb begin
    w_tap_nxt[0] = bus.in_sample;
    for (int j = 1; j < TAPS; j++) w_tap_nxt[j] = r_tap[j-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_tap <= '{default: '0};
    else if (clear)    r_tap <= '{default: '0};
    else if (w_accept) r_tap <= w_tap_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (clear || w_accept || w_wrap) begin
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_step) begin
      r_idx  <= w_idx_inc;
      r_last <= (w_idx_inc == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_count <= '0;
    else if (clear)                         r_count <= '0;
    else if (w_accept && r_count != FULL_CNT) r_count <= r_count + CW'(1);
  end

  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    tap_bit_serializer #(.WIDTH(WIDTH)) u_ser (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clear (clear),
      .i_load  (w_accept),
      .i_shift (w_step),
      .i_din   (w_tap_nxt[j]),
      .o_bit   (w_slice[j])
    );
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.slice_valid = (r_state == BUSY);
  assign bus.slice       = w_slice;
  assign bus.slice_idx   = r_idx;
  assign bus.slice_last  = r_last;
  assign bus.line_full   = (r_count == FULL_CNT);

endmodule
